aux_uart_tx: RTL and testbench
==============================

// Module: aux_uart_tx
// PURPOSE
//  Aux-bus responder: memory-mapped UART transmitter on the core's 16-bit aux bus.
//  The core writes bytes into a TX FIFO. A baud divisor paces an 8N1 serializer on tx_o.
//  Reads are combinational; the aux bus has no read strobe, so reads have no side effects.
// PARAMETERS
//  BASE_ADDR     16'hFF00  aux address of register 0; registers occupy BASE_ADDR+0..+4
//  FIFO_AW       3         log2 of TX FIFO depth (default depth 8)
//  RST_DIVISOR   16'd103   reset value of the {BAUD_HI,BAUD_LO} divisor
// PORTS
//  clk_i       in   1   clock
//  reset_n_i   in   1   asynchronous reset, active low
//  clk_en_i    in   1   clock enable; all state advances only when high
//  aux_adr_i   in   16  aux address from the core
//  aux_dat_io  io   8   aux data, tri-state; driven only on a read hit
//  aux_we_i    in   1   aux write strobe, active high; sampled at posedge clk_i
//  tx_o        out  1   serial output, idle high
//  irq_o       out  1   TX-empty interrupt, level, active high
// BEHAVIOUR
//  Reset (async, reset_n_i=0): tx_o=1, irq_o=0, aux_dat_io=Z, FIFO empty, FSM IDLE.
//   Also: overflow=0, divisor=RST_DIVISOR, CTRL=0. tx_o returns high immediately.
//  Decode: hit = aux_adr_i within BASE_ADDR..BASE_ADDR+4.
//   aux_dat_io = (hit & !aux_we_i) ? rdata : 8'hZZ.
//  Register map (offset: read / write):
//   +0 DATA  : R {(7-FIFO_AW)'0, count} / W push byte into FIFO
//   +1 STAT  : R {4'b0, ovf, empty, full, busy} / W bit3=1 clears ovf
//   +2 BAUD_LO, +3 BAUD_HI : R/W divisor[7:0], divisor[15:8]
//   +4 CTRL  : bit0 tx_en, bit1 flush (write-only, self-clearing, reads 0), bit2 irq_en
//  Writes commit at a posedge with aux_we_i & hit & clk_en_i. Unused bits read 0.
//  FIFO: depth 2**FIFO_AW; count is FIFO_AW+1 bits wide; pointers wrap modulo depth.
//   Push when full: byte dropped, ovf set (sticky). The full test uses pre-edge count,
//   even when a pop happens on the same edge.
//   Push and pop on the same edge, not full: count unchanged.
//   Flush: count=0, pointers reset. An in-flight frame completes. Flush with
//   simultaneous push: flush wins and the byte is discarded.
//  Baud: bit period = divisor+1 enabled cycles; divisor=0 gives 1 cycle per bit.
//   The counter reloads from the current divisor at each bit boundary. A divisor
//   change mid-frame applies from the next bit.
//  FSM: IDLE -> START -> DATA -> STOP -> (IDLE | START).
//   IDLE : tx_o=1; if tx_en & !empty, pop into shift reg, go to START.
//   START: tx_o=0 for one bit period.
//   DATA : tx_o=shift[0], LSB first, 8 bit periods; 3-bit bit counter.
//   STOP : tx_o=1 for one bit period. Then, if tx_en & !empty, pop and go straight
//          to START (back-to-back frames); else go to IDLE.
//  busy = (state != IDLE). Clearing tx_en mid-frame finishes the frame; no further pops.
//  Latency: DATA write committed at edge N (FSM idle, tx_en=1) -> pop and tx_o=0
//   after edge N+1. Frame length is 10 bit periods.
//  irq_o = irq_en & tx_en & empty & !busy, registered (one-cycle lag).
//  clk_en_i=0 freezes all state, including writes and the baud counter.
// TESTING
//  1 Reset: hold reset_n_i=0 -> tx_o=1, irq_o=0, aux_dat_io=Z.
//    Read +2/+3 -> 8'h67/8'h00.
//  2 Write divisor=3, CTRL=1, DATA=8'hA5 -> tx_o low 2 cycles after the write.
//    Then bits 1,0,1,0,0,1,0,1, then stop bit; each bit 4 cycles; 40 cycles total.
//  3 Write 9 bytes with tx_en=0 -> DATA reads 8, STAT=8'h0A (ovf, full).
//    Write STAT=8'h08 -> ovf cleared.
//  4 Write 2 bytes, tx_en=1 -> frames are back-to-back with no idle gap.
//    CTRL=5 (tx_en, irq_en): irq_o rises 1 cycle after the second stop bit ends.
//  5 Mid-frame: pulse reset_n_i low -> tx_o=1 immediately; FIFO empty after release.
//    Repeat with a flush instead -> current frame completes, then IDLE.
//  6 Miss/read checks: address outside BASE_ADDR..+4 -> aux_dat_io=Z and no state change.
//    clk_en_i=0 for 10 cycles mid-bit -> bit period is stretched by exactly 10 cycles.

Source files
------------

// File: rtl/aux_uart_tx_if.sv
// aux_uart_tx_if: core aux bus (address, write strobe, shared tri-state data) for the UART responder
interface aux_uart_tx_if;
   logic [15:0] aux_adr;
   logic        aux_we;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        rd_oe;
   wire  [7:0]  aux_dat;
   // single resolution point: responder drives on a read hit, core drives while writing
   assign aux_dat = rd_oe ? rdata : aux_we ? wdata : 8'hzz;
   modport master(output aux_adr, aux_we, wdata, input aux_dat, rd_oe);
   modport slave(input aux_adr, aux_we, aux_dat, output rdata, rd_oe);
endinterface

// File: rtl/aux_uart_tx.sv
// aux_uart_tx: aux-bus mapped 8N1 UART transmitter with TX FIFO, baud divisor and TX-empty irq
module aux_uart_tx #(
   parameter logic [15:0] BASE_ADDR   = 16'hFF00,
   parameter int          FIFO_AW     = 3,
   parameter logic [15:0] RST_DIVISOR = 16'd103
) (
   input  logic           clk_i,
   input  logic           reset_n_i,
   input  logic           clk_en_i,
   aux_uart_tx_if.slave   aux,
   output logic           tx_o,
   output logic           irq_o
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW = FIFO_AW + 1;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_n;
   logic [7:0] mem [DEPTH];
   logic [FIFO_AW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic [15:0] off, divisor, baud_cnt;
   logic [7:0] shift, rdata;
   logic [2:0] bit_cnt;
   logic ovf, tx_en, irq_en, hit, we, push, push_ok, full, empty, busy, flush, tick, pop;
   assign off = aux.aux_adr - BASE_ADDR;
   assign hit = aux.aux_adr >= BASE_ADDR && off < 16'd5;
   assign we = aux.aux_we & hit & clk_en_i;
   assign push = we && off == 16'd0;
   assign flush = we && off == 16'd4 && aux.aux_dat[1];
   // count never exceeds DEPTH, so its top bit alone marks full
   assign full = count[FIFO_AW];
   assign push_ok = push & ~full;
   assign empty = count == '0;
   assign busy = state != IDLE;
   assign tick = baud_cnt == 16'd0;
   assign tx_o = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
   always_comb begin
      rdata = off == 16'd0 ? 8'(count) :
              off == 16'd1 ? {4'b0, ovf, empty, full, busy} :
              off == 16'd2 ? divisor[7:0] :
              off == 16'd3 ? divisor[15:8] : {5'b0, irq_en, 1'b0, tx_en};
      aux.rdata = rdata;
      aux.rd_oe = hit & ~aux.aux_we;
   end
   always_comb begin
      state_n = state;
      pop = 1'b0;
      if (clk_en_i)
         case (state)
            IDLE: if (tx_en && !empty && !flush) begin pop = 1'b1; state_n = START; end
            START: if (tick) state_n = DATA;
            DATA: if (tick && bit_cnt == 3'd7) state_n = STOP;
            STOP: if (tick) begin pop = tx_en && !empty && !flush; state_n = pop ? START : IDLE; end
            default: state_n = IDLE;
         endcase
   end
   always_ff @(posedge clk_i)
      if (clk_en_i && push_ok) mem[wptr] <= aux.aux_dat;
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         state <= IDLE;
         wptr <= '0;
         rptr <= '0;
         count <= '0;
         ovf <= 1'b0;
         divisor <= RST_DIVISOR;
         tx_en <= 1'b0;
         irq_en <= 1'b0;
         shift <= '0;
         bit_cnt <= '0;
         baud_cnt <= '0;
         irq_o <= 1'b0;
      end else if (clk_en_i) begin
         state <= state_n;
         irq_o <= irq_en & tx_en & empty & ~busy;
         if (flush) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
         end else begin
            if (push_ok) wptr <= wptr + FIFO_AW'(1);
            if (pop) rptr <= rptr + FIFO_AW'(1);
            count <= count + CW'(push_ok) - CW'(pop);
         end
         if (push && full) ovf <= 1'b1;
         else if (we && off == 16'd1 && aux.aux_dat[3]) ovf <= 1'b0;
         if (we && off == 16'd2) divisor[7:0] <= aux.aux_dat;
         if (we && off == 16'd3) divisor[15:8] <= aux.aux_dat;
         if (we && off == 16'd4) begin
            tx_en <= aux.aux_dat[0];
            irq_en <= aux.aux_dat[2];
         end
         // the divisor is re-read at every bit boundary so changes land on the next bit
         if (pop) begin
            shift <= mem[rptr];
            baud_cnt <= divisor;
         end else if (busy) begin
            baud_cnt <= tick ? divisor : baud_cnt - 16'd1;
            if (tick && state == START) bit_cnt <= '0;
            if (tick && state == DATA) begin
               shift <= shift >> 1;
               bit_cnt <= bit_cnt + 3'd1;
            end
         end
      end
endmodule

// File: tb/tb_aux_uart_tx.sv
// tb_aux_uart_tx: directed and randomized checks of the aux-bus UART against a waveform-level model
module tb_aux_uart_tx;
   localparam logic [15:0] BASE = 16'hFF00;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clk_en = 1'b1;
   logic tx, irq;
   int checks = 0;
   int errors = 0;
   aux_uart_tx_if ifc();
   aux_uart_tx dut(.clk_i(clk), .reset_n_i(rst_n), .clk_en_i(clk_en), .aux(ifc.slave), .tx_o(tx), .irq_o(irq));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      ifc.aux_adr = a;
      ifc.wdata = d;
      ifc.aux_we = 1'b1;
      @(negedge clk);
      ifc.aux_we = 1'b0;
      ifc.aux_adr = 16'h0000;
   endtask

   task automatic rd(input logic [15:0] a, output logic [7:0] d, output logic oe);
      ifc.aux_adr = a;
      #1;
      d = ifc.aux_dat;
      oe = ifc.rd_oe;
      ifc.aux_adr = 16'h0000;
   endtask

   // a read hit must drive the bus and return exp
   task automatic chk_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
      logic [7:0] d;
      logic oe;
      rd(a, d, oe);
      chk(tag, {7'b0, oe, d}, {8'h01, exp});
   endtask

   // every cycle of a frame: start 0, 8 data bits LSB first, stop 1, each p cycles long
   task automatic frame_check(input logic [7:0] b, input int p, input int flush_at, input int stall_at, input string tag);
      int bad = 0;
      logic e;
      for (int k = 0; k < 10 * p; k++) begin
         e = (k / p == 0) ? 1'b0 : (k / p == 9) ? 1'b1 : b[k / p - 1];
         if (tx !== e) bad++;
         if (k == flush_at) begin
            ifc.aux_adr = BASE + 16'd4;
            ifc.wdata = 8'h03;
            ifc.aux_we = 1'b1;
         end
         if (k == flush_at + 1) begin
            ifc.aux_we = 1'b0;
            ifc.aux_adr = 16'h0000;
         end
         if (k == stall_at) begin
            clk_en = 1'b0;
            repeat (10) begin
               @(negedge clk);
               if (tx !== e) bad++;
            end
            clk_en = 1'b1;
         end
         @(negedge clk);
      end
      chk(tag, 16'(bad), 16'd0);
   endtask

   initial begin
      logic [7:0] d, b;
      logic oe;
      logic [7:0] q[$];
      int n, div;
      ifc.aux_adr = 16'h0000;
      ifc.aux_we = 1'b0;
      ifc.wdata = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_tx", {15'b0, tx}, 16'd1);
      chk("rst_irq", {15'b0, irq}, 16'd0);
      rd(16'h0000, d, oe);
      chk("rst_bus_z", {15'b0, oe}, 16'd0);
      chk_rd("rst_baud_lo", BASE + 16'd2, 8'h67);
      chk_rd("rst_baud_hi", BASE + 16'd3, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
      chk_rd("rst_stat", BASE + 16'd1, 8'h04);

      wr(BASE + 16'd2, 8'd3);
      wr(BASE + 16'd3, 8'd0);
      wr(BASE + 16'd4, 8'h01);
      wr(BASE, 8'hA5);
      chk("lat_idle", {15'b0, tx}, 16'd1);
      @(negedge clk);
      frame_check(8'hA5, 4, -1, -1, "frame_a5");
      chk_rd("a5_done_stat", BASE + 16'd1, 8'h04);

      wr(BASE + 16'd4, 8'h00);
      for (int i = 0; i < 8; i++) wr(BASE, 8'(i));
      chk_rd("full_stat", BASE + 16'd1, 8'h02);
      wr(BASE, 8'hEE);
      chk_rd("ovf_count", BASE, 8'h08);
      chk_rd("ovf_stat", BASE + 16'd1, 8'h0A);
      wr(BASE + 16'd1, 8'h08);
      chk_rd("ovf_clear", BASE + 16'd1, 8'h02);
      wr(BASE + 16'd4, 8'h02);
      chk_rd("flush_count", BASE, 8'h00);
      chk_rd("flush_stat", BASE + 16'd1, 8'h04);

      for (int r = 0; r < 4; r++) begin
         div = $urandom_range(0, 4);
         n = $urandom_range(2, 4);
         wr(BASE + 16'd4, 8'h04);
         wr(BASE + 16'd2, 8'(div));
         wr(BASE + 16'd3, 8'h00);
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            wr(BASE, b);
         end
         chk_rd("rnd_count", BASE, 8'(n));
         wr(BASE + 16'd4, 8'h05);
         @(negedge clk);
         while (q.size() > 0) frame_check(q.pop_front(), div + 1, -1, -1, "rnd_frame");
         chk("irq_lag", {14'b0, tx, irq}, 16'h0002);
         @(negedge clk);
         chk("irq_rise", {15'b0, irq}, 16'd1);
      end

      wr(BASE + 16'd2, 8'd3);
      wr(BASE + 16'd3, 8'd0);
      wr(BASE + 16'd4, 8'h01);
      wr(BASE, 8'h00);
      @(negedge clk);
      repeat (8) @(negedge clk);
      chk("pre_rst_tx", {15'b0, tx}, 16'd0);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_tx", {14'b0, tx, irq}, 16'h0002);
      @(negedge clk);
      rst_n = 1'b1;
      chk_rd("post_rst_stat", BASE + 16'd1, 8'h04);
      chk_rd("post_rst_count", BASE, 8'h00);
      chk_rd("post_rst_baud", BASE + 16'd2, 8'h67);

      wr(BASE + 16'd2, 8'd3);
      wr(BASE, 8'h11);
      wr(BASE, 8'h22);
      wr(BASE + 16'd4, 8'h01);
      @(negedge clk);
      frame_check(8'h11, 4, 9, -1, "flush_frame");
      chk_rd("flush_idle_stat", BASE + 16'd1, 8'h04);
      repeat (6) @(negedge clk);
      chk("flush_no_frame", {15'b0, tx}, 16'd1);
      chk_rd("flush_still_idle", BASE + 16'd1, 8'h04);
      chk_rd("ctrl_readback", BASE + 16'd4, 8'h01);

      rd(BASE - 16'd1, d, oe);
      chk("miss_below", {15'b0, oe}, 16'd0);
      rd(BASE + 16'd5, d, oe);
      chk("miss_above", {15'b0, oe}, 16'd0);
      wr(BASE + 16'd5, 8'hFF);
      wr(BASE - 16'd1, 8'hFF);
      chk_rd("miss_count", BASE, 8'h00);
      chk_rd("miss_stat", BASE + 16'd1, 8'h04);
      chk_rd("miss_ctrl", BASE + 16'd4, 8'h01);
      chk_rd("miss_baud", BASE + 16'd2, 8'h03);

      wr(BASE, 8'h3C);
      @(negedge clk);
      frame_check(8'h3C, 4, -1, 9, "stall_frame");
      chk_rd("stall_done", BASE + 16'd1, 8'h04);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
